// File: rtl/register.sv
// Clock-enabled data register with an asynchronous, active-high reset.
// Define REGISTER_CHANGED_EN to add the registered `changed` output.
module register #(
   parameter int unsigned WIDTH       = 16,
   parameter logic [63:0] RESET_VALUE = 64'd0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] value_in,
   output logic [WIDTH-1:0] value_out
`ifdef REGISTER_CHANGED_EN
   ,
   output logic             changed
`endif
);

   localparam logic [WIDTH-1:0] RST_VALUE = RESET_VALUE[WIDTH-1:0];

   logic [WIDTH-1:0] value_d;
   logic [WIDTH-1:0] value_q;

   // NOTE: assign a default first so every path drives value_d and no latch is inferred.
   always_comb begin
      value_d = value_q;
      if (enable) begin
         value_d = value_in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value_q <= RST_VALUE;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_out = value_q;

`ifdef REGISTER_CHANGED_EN
   logic changed_d;
   logic changed_q;

   // Reset forces the flop low, so the reset==0 term is implied here.
   always_comb begin
      changed_d = enable && (value_in != value_q);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         changed_q <= 1'b0;
      end else begin
         changed_q <= changed_d;
      end
   end

   assign changed = changed_q;
`endif

endmodule

// File: tb/tb_register.sv
// Self-checking bench for register: directed steps followed by randomized cycles
// checked against a behavioural model of the load/hold/reset rules.
module tb_register;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [15:0] value_in;
   logic [15:0] value_out;
`ifdef REGISTER_CHANGED_EN
   logic        changed;
`endif

   int compared   = 0;
   int mismatched = 0;

   // Behavioural model state
   logic [15:0] exp_val;
   logic        exp_chg;

   register #(
      .WIDTH      (16),
      .RESET_VALUE(64'd0)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .value_in (value_in),
      .value_out(value_out)
`ifdef REGISTER_CHANGED_EN
      ,
      .changed  (changed)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check(tag, value_out, exp_val);
`ifdef REGISTER_CHANGED_EN
      check({tag, "_chg"}, {15'd0, changed}, {15'd0, exp_chg});
`endif
   endtask

   // Drive inputs at the falling edge, then apply the spec rules at the rising edge.
   task automatic cycle(input string tag, input logic r, input logic e, input logic [15:0] d);
      @(negedge clock);
      reset    = r;
      enable   = e;
      value_in = d;
      if (r) begin
         #1;
         exp_val = 16'd0;
         exp_chg = 1'b0;
         check_outputs({tag, "_async"});
      end
      @(posedge clock);
      exp_chg = !r && e && (d != exp_val);
      if (r)      exp_val = 16'd0;
      else if (e) exp_val = d;
      #1;
      check_outputs(tag);
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b1;
      value_in = 16'hFFFF;
      exp_val  = 16'd0;
      exp_chg  = 1'b0;
      #1;
      check_outputs("rst_immediate");
      cycle("rst_c1", 1'b1, 1'b1, 16'hFFFF);
      cycle("rst_c2", 1'b1, 1'b1, 16'hFFFF);

      // Load 31, keep it a few cycles, then 127
      cycle("load31",   1'b0, 1'b1, 16'd31);
      cycle("reload31", 1'b0, 1'b1, 16'd31);
      cycle("reload31b",1'b0, 1'b1, 16'd31);
      cycle("load127",  1'b0, 1'b1, 16'd127);

      // Hold with a changing value_in
      cycle("hold1", 1'b0, 1'b0, 16'd1023);
      cycle("hold2", 1'b0, 1'b0, 16'd1023);
      cycle("hold3", 1'b0, 1'b0, 16'd1023);

      // Glitch on enable/value_in between edges must be ignored
      @(negedge clock);
      enable   = 1'b1;
      value_in = 16'hAAAA;
      #2;
      enable   = 1'b0;
      value_in = 16'd1023;
      @(posedge clock);
      exp_chg = 1'b0;
      #1;
      check_outputs("glitch_hold");

      cycle("reenable", 1'b0, 1'b1, 16'd1023);

      // Reset pulse between edges clears at once; reload on first edge after release
      #2;
      reset = 1'b1;
      #1;
      exp_val = 16'd0;
      exp_chg = 1'b0;
      check_outputs("mid_rst");
      enable   = 1'b1;
      value_in = 16'd5;
      #1;
      reset = 1'b0;
      cycle("reload5", 1'b0, 1'b1, 16'd5);

      // Reset held across an edge discards the pending load
      cycle("rst_discard", 1'b1, 1'b1, 16'h1234);
      cycle("after_rst5",  1'b0, 1'b1, 16'd5);

      // changed pulse pattern: 0 then 5,5,9, then hold
      cycle("chg_load0", 1'b0, 1'b1, 16'd0);
      cycle("chg_load5", 1'b0, 1'b1, 16'd5);
      cycle("chg_same5", 1'b0, 1'b1, 16'd5);
      cycle("chg_load9", 1'b0, 1'b1, 16'd9);
      cycle("chg_hold",  1'b0, 1'b0, 16'd7);

      // Randomized traffic with occasional reset
      for (int i = 0; i < 300; i++) begin
         cycle("rand",
               ($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 1)),
               16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
